ex_div_seq: RTL
===============

// Module: ex_div_seq
// PURPOSE
// - Multi-cycle sequencer for the RV32M divide group (DIV/DIVU/REM/REMU) beside the EX-stage ALU.
// - Captures the forwarded operands and runs an iterative restoring divide.
// - Holds the pipeline with div_stall until the result is ready.
// - Presents the result for one cycle so the EX/MEM register captures it in place of alu_out.
// PARAMETERS
// - XLEN            32  operand/result width
// - STEPS_PER_CYCLE 1   quotient bits produced per CALC cycle; legal 1, 2, 4 (must divide XLEN)
// PORTS
// - clk          in   1     core clock
// - rst          in   1     reset; asynchronous, active-high
// - ex_flush     in   1     kill the instruction in EX; aborts any divide
// - div_req      in   1     valid divide-group instruction present in EX
// - div_opcode   in   2     0=DIV 1=DIVU 2=REM 3=REMU (core package enum)
// - div_dividend in   XLEN  forwarded rs1 value
// - div_divisor  in   XLEN  forwarded rs2 value
// - div_stall    out  1     to hazard control; ORed into ex_stall/id stall
// - div_done     out  1     result valid this cycle
// - div_result   out  XLEN  quotient or remainder, per opcode
// BEHAVIOUR
// - Reset values: state=IDLE, counter=0, all datapath regs=0; div_stall=0, div_done=0, div_result=0.
// - States:
//   - IDLE: accepting.
//   - CALC: iterating.
//   - DONE: result held, one cycle.
// - IDLE & div_req & ~ex_flush:
//   - Capture opcode, operand signs, and |dividend|, |divisor| (absolute values only for DIV/REM).
//   - Divisor==0 or (signed & dividend==0x8000_0000 & divisor==0xFFFF_FFFF): load the special result and go to DONE.
//   - Otherwise: clear remainder, counter=0, go to CALC.
// - CALC, per step:
//   - {rem,quo} <<= 1.
//   - If rem>=divisor: rem -= divisor and quo[0]=1.
//   - STEPS_PER_CYCLE steps per cycle; after XLEN/STEPS_PER_CYCLE cycles go to DONE.
//   - Arithmetic uses XLEN+1-bit trial subtract; no other width growth.
// - DONE:
//   - div_done=1; div_result registered.
//   - Next state is IDLE unconditionally; div_req in DONE is ignored (same instruction still in EX).
// - Sign fixup, applied at the CALC->DONE transition:
//   - Quotient is negated if signed & sign(dividend)!=sign(divisor).
//   - Remainder takes the sign of the dividend.
// - Special results:
//   - Divide by zero: quotient=0xFFFF_FFFF, remainder=dividend.
//   - Signed overflow: quotient=0x8000_0000, remainder=0.
// - div_stall = ~ex_flush & ((IDLE & div_req) | CALC). It is combinational and deasserts in DONE so EX advances that cycle.
// - Latency:
//   - Normal: stall for 1+XLEN/STEPS_PER_CYCLE cycles; the result is captured at the end of the DONE cycle.
//   - Special case: stall for 1 cycle.
// - ex_flush in any state:
//   - Next state=IDLE; div_done forced 0 that cycle; no result is produced.
//   - A div_req arriving together with ex_flush in IDLE is not accepted.
// - Operands are sampled only on acceptance; later changes of the div_* inputs (forwarding settling) are ignored until IDLE.
// - An asynchronous rst mid-CALC returns immediately to the reset values; no partial result is visible.
// - Back-to-back divides: the second is accepted in the IDLE cycle following DONE. No dead cycles beyond that.
// STRUCTURE
// - In the core package:
//   - div_op_e enum (DIV/DIVU/REM/REMU).
//   - div_state_e enum (IDLE/CALC/DONE).
//   - `DIV_CNT_RANGE macro in core.svh.
// - One natural sub-module: div_step (combinational STEPS_PER_CYCLE-deep restoring-step array, parameterised by XLEN/STEPS_PER_CYCLE).
// - The FSM, counter and sign fixup stay in ex_div_seq.
// TESTING
// - DIVU 100/7: stall 33 cycles (STEPS=1), div_done 1 cycle, result=14. REMU same operands -> 2.
// - DIV -7/2 -> 0xFFFF_FFFD (-3). REM -7/2 -> 0xFFFF_FFFF (-1). REM 7/-2 -> 1.
// - DIV 5/0 -> 0xFFFF_FFFF and REM 5/0 -> 5, each with exactly 1 stall cycle. DIV 0x8000_0000/-1 -> 0x8000_0000, REM -> 0.
// - ex_flush at CALC cycle 10:
//   - Next cycle IDLE, div_stall=0, div_done never asserts.
//   - A new DIVU 9/3 then returns 3.
// - Assert rst asynchronously mid-CALC: outputs 0 immediately; after release, DIVU 0xFFFF_FFFF/1 -> 0xFFFF_FFFF.
// - Back-to-back DIVU 10/3 then REMU 10/3 -> 3 then 1. Operands changed during CALC must not alter the result. Repeat all with STEPS_PER_CYCLE=4 (9-cycle stall).

Source files
------------

// File: rtl/ex_div_seq_pkg.sv
// Shared types for the EX-stage divide sequencer: opcode and FSM state encodings
// plus small decode helpers.
package ex_div_seq_pkg;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'd0,
    DIV_OP_DIVU = 2'd1,
    DIV_OP_REM  = 2'd2,
    DIV_OP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic op_is_signed(div_op_e op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic op_is_rem(div_op_e op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

  // Width of the CALC iteration counter for a given number of CALC cycles.
  function automatic int div_cnt_w(int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/ex_div_seq_step.sv
// Combinational array of STEPS restoring-divide steps on an unsigned {rem,quo} pair.
module ex_div_seq_step
  import ex_div_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int STEPS = 1
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN-1:0] rem_s [0:STEPS];
  logic [XLEN-1:0] quo_s [0:STEPS];

  assign rem_s[0] = rem_in;
  assign quo_s[0] = quo_in;

  for (genvar i = 0; i < STEPS; i++) begin : g_step
    logic [XLEN:0] trial;
    logic [XLEN:0] diff;
    assign trial = {rem_s[i], quo_s[i][XLEN-1]};
    // rem < divisor holds, so trial < 2*divisor and diff[XLEN] is the borrow.
    assign diff         = trial - {1'b0, divisor};
    assign rem_s[i+1]   = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_s[i+1]   = {quo_s[i][XLEN-2:0], ~diff[XLEN]};
  end

  assign rem_out = rem_s[STEPS];
  assign quo_out = quo_s[STEPS];

endmodule

// File: rtl/ex_div_seq.sv
// RV32M divide-group sequencer beside the EX ALU: accepts one DIV/DIVU/REM/REMU,
// stalls the pipe while iterating, then presents the result for one DONE cycle.
module ex_div_seq
  import ex_div_seq_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_flush,
  input  logic            div_req,
  input  logic [1:0]      div_opcode,
  input  logic [XLEN-1:0] div_dividend,
  input  logic [XLEN-1:0] div_divisor,
  output logic            div_stall,
  output logic            div_done,
  output logic [XLEN-1:0] div_result
);

  localparam int                CYCLES   = XLEN / STEPS_PER_CYCLE;
  localparam int                CNT_W    = div_cnt_w(CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CYCLES - 1);
  localparam logic [XLEN-1:0]   MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state, state_nx;
  logic [CNT_W-1:0] cnt;
  div_op_e         op_q;
  logic            dvd_neg_q, dvs_neg_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, result_q;
  logic [XLEN-1:0] rem_nx, quo_nx, quo_fix, rem_fix;

  logic            accept, in_signed, dvd_neg_in, dvs_neg_in, div_zero, ovf, special;
  logic [XLEN-1:0] dvd_abs, dvs_abs, special_res;
  div_op_e         op_in;

  ex_div_seq_step #(.XLEN(XLEN), .STEPS(STEPS_PER_CYCLE)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  // Acceptance decode on the live forwarded operands.
  always_comb begin
    op_in       = div_op_e'(div_opcode);
    accept      = (state == DIV_IDLE) && div_req && !ex_flush;
    in_signed   = op_is_signed(op_in);
    dvd_neg_in  = in_signed && div_dividend[XLEN-1];
    dvs_neg_in  = in_signed && div_divisor[XLEN-1];
    dvd_abs     = dvd_neg_in ? -div_dividend : div_dividend;
    dvs_abs     = dvs_neg_in ? -div_divisor : div_divisor;
    div_zero    = (div_divisor == '0);
    ovf         = in_signed && (div_dividend == MIN_NEG) && (div_divisor == '1);
    special     = div_zero || ovf;
    if (op_is_rem(op_in)) special_res = div_zero ? div_dividend : '0;
    else                  special_res = div_zero ? '1 : MIN_NEG;
  end

  // Sign fixup of the final iteration; dvd_neg_q/dvs_neg_q are already qualified by signedness.
  always_comb begin
    quo_fix = (dvd_neg_q ^ dvs_neg_q) ? -quo_nx : quo_nx;
    rem_fix = dvd_neg_q ? -rem_nx : rem_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      DIV_IDLE: if (accept) state_nx = special ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (cnt == CNT_LAST) state_nx = DIV_DONE;
      DIV_DONE: state_nx = DIV_IDLE;
      default:  state_nx = DIV_IDLE;
    endcase
    if (ex_flush) state_nx = DIV_IDLE;
  end

  assign div_stall  = !ex_flush && (((state == DIV_IDLE) && div_req) || (state == DIV_CALC));
  assign div_done   = (state == DIV_DONE) && !ex_flush;
  assign div_result = result_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DIV_IDLE;
      cnt       <= '0;
      op_q      <= DIV_OP_DIV;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q      <= op_in;
        dvd_neg_q <= dvd_neg_in;
        dvs_neg_q <= dvs_neg_in;
        dvs_q     <= dvs_abs;
        quo_q     <= dvd_abs;
        rem_q     <= '0;
        cnt       <= '0;
        if (special) result_q <= special_res;
      end else if ((state == DIV_CALC) && !ex_flush) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt   <= cnt + 1'b1;
        if (cnt == CNT_LAST) result_q <= op_is_rem(op_q) ? rem_fix : quo_fix;
      end
    end
  end

endmodule
